// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Moves one 512-bit cache line at a time between the memory
//               side of the cache arbiter and a 64-bit tagged system bus.
//               A read sends a tagged line request, collects BEATS response
//               beats and returns the assembled line. A write sends a tagged
//               request and then streams BEATS data beats. Only one
//               transaction is outstanding at any time.
//
// Ports       : clk, rst            clock, synchronous active-high reset
//               mem_req/mem_wr_en    arbiter request, direction (1 = write)
//               mem_address          byte address (line offset ignored)
//               mem_data_out         write line, sampled with mem_req
//               data_from_mem        read line, valid with mem_data_valid
//               mem_data_valid       one-cycle completion pulse
//               mem_busy             high whenever the FSM is not idle
//               mem_error            watchdog timeout pulse
//               bus_reqcyc/req/tag   bus request word, held until bus_reqack
//               bus_respcyc/resp/tag bus response beat
//               bus_respack          same-cycle acknowledge of a response beat
//
// Options     : MEM_BUS_CTRL_TIMEOUT_EN - when defined, a watchdog aborts a
//               transaction after TIMEOUT_CYCLES cycles without progress and
//               pulses mem_error. When undefined mem_error is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
  parameter int          ADDR_W         = 64,
  parameter int          LINE_W         = 512,
  parameter int          BUS_W          = 64,
  parameter logic [12:0] RD_TAG         = 13'h1100,
  parameter logic [12:0] WR_TAG         = 13'h0100,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_data_out,
  output logic [LINE_W-1:0] data_from_mem,
  output logic              mem_data_valid,
  output logic              mem_busy,
  output logic              mem_error,
  output logic              bus_reqcyc,
  output logic [BUS_W-1:0]  bus_req,
  output logic [12:0]       bus_reqtag,
  input  logic              bus_reqack,
  input  logic              bus_respcyc,
  input  logic [BUS_W-1:0]  bus_resp,
  input  logic [12:0]       bus_resptag,
  output logic              bus_respack
);

  localparam int c_BEATS = LINE_W / BUS_W;
  localparam int c_CNT_W = $clog2(c_BEATS);
  localparam int c_OFF_W = $clog2(LINE_W / 8);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_RESP = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_line;
  logic [LINE_W-1:0]   r_data_out;
  logic                r_valid;

  logic                w_beat_ok;
  logic [LINE_W-1:0]   w_line_upd;
  logic [BUS_W-1:0]    w_wr_beat;

  // The line offset bits never reach the bus; the request is line aligned.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^mem_address[c_OFF_W-1:0];

  // A response beat is taken only in RD_RESP and only with the read tag;
  // foreign-tagged beats are left for whoever owns them.
  assign w_beat_ok   = (r_state == S_RD_RESP) && bus_respcyc && (bus_resptag == RD_TAG);
  assign bus_respack = w_beat_ok;

  assign w_wr_beat = r_line[int'(r_cnt) * BUS_W +: BUS_W];

  // Line buffer with the incoming beat merged in, so the final beat can be
  // presented on data_from_mem in the DONE cycle itself.
  always_comb begin
    w_line_upd = r_line;
    w_line_upd[int'(r_cnt) * BUS_W +: BUS_W] = bus_resp;
  end

  assign bus_reqcyc     = (r_state == S_RD_REQ) || (r_state == S_WR_REQ) || (r_state == S_WR_DATA);
  assign mem_busy       = (r_state != S_IDLE);
  assign mem_data_valid = r_valid;
  assign data_from_mem  = r_data_out;

  always_comb begin
    bus_req    = '0;
    bus_reqtag = 13'h0;
    case (r_state)
      S_RD_REQ: begin
        bus_req    = BUS_W'(r_addr);
        bus_reqtag = RD_TAG;
      end
      S_WR_REQ: begin
        bus_req    = BUS_W'(r_addr);
        bus_reqtag = WR_TAG;
      end
      S_WR_DATA: begin
        bus_req    = w_wr_beat;
        bus_reqtag = WR_TAG;
      end
      default: begin
        bus_req    = '0;
        bus_reqtag = 13'h0;
      end
    endcase
  end

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
  localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [c_WDOG_W-1:0] r_wdog;
  logic                r_error;
  logic                w_wait_state;
  logic                w_progress;

  assign w_wait_state = (r_state == S_RD_REQ) || (r_state == S_RD_RESP) ||
                        (r_state == S_WR_REQ) || (r_state == S_WR_DATA);
  assign w_progress   = (bus_reqack && bus_reqcyc) || w_beat_ok;
  assign mem_error    = r_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign mem_error        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_line     <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
      r_wdog     <= '0;
      r_error    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
      r_error <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (mem_req) begin
            r_addr  <= {mem_address[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
            r_line  <= mem_wr_en ? mem_data_out : '0;
            r_cnt   <= '0;
            r_state <= mem_wr_en ? S_WR_REQ : S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (bus_reqack) begin
            r_cnt   <= '0;
            r_state <= S_RD_RESP;
          end
        end
        S_WR_REQ: begin
          if (bus_reqack) begin
            r_cnt   <= '0;
            r_state <= S_WR_DATA;
          end
        end
        S_RD_RESP: begin
          if (w_beat_ok) begin
            r_line <= w_line_upd;
            // Stop on the last beat so the counter never wraps.
            if (r_cnt == c_LAST) begin
              r_state    <= S_DONE;
              r_valid    <= 1'b1;
              r_data_out <= w_line_upd;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_WR_DATA: begin
          if (bus_reqack) begin
            if (r_cnt == c_LAST) begin
              r_state    <= S_DONE;
              r_valid    <= 1'b1;
              r_data_out <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
      // Watchdog overrides the normal next-state when it expires.
      if (w_wait_state) begin
        if (w_progress) begin
          r_wdog <= '0;
        end else if (r_wdog == c_WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          r_wdog     <= '0;
          r_state    <= S_IDLE;
          r_valid    <= 1'b1;
          r_error    <= 1'b1;
          r_data_out <= '0;
        end else begin
          r_wdog <= r_wdog + 1'b1;
        end
      end else begin
        r_wdog <= '0;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Directed self-checking bench for mem_bus_ctrl. Inputs change
//               just after the falling edge; outputs are sampled 1 time unit
//               later, well clear of the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

  localparam logic [12:0] c_RD_TAG = 13'h1100;
  localparam logic [12:0] c_WR_TAG = 13'h0100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_req = 1'b0;
  logic         mem_wr_en = 1'b0;
  logic [63:0]  mem_address = '0;
  logic [511:0] mem_data_out = '0;
  logic [511:0] data_from_mem;
  logic         mem_data_valid;
  logic         mem_busy;
  logic         mem_error;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack = 1'b0;
  logic         bus_respcyc = 1'b0;
  logic [63:0]  bus_resp = '0;
  logic [12:0]  bus_resptag = '0;
  logic         bus_respack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_wr_en      (mem_wr_en),
    .mem_address    (mem_address),
    .mem_data_out   (mem_data_out),
    .data_from_mem  (data_from_mem),
    .mem_data_valid (mem_data_valid),
    .mem_busy       (mem_busy),
    .mem_error      (mem_error),
    .bus_reqcyc     (bus_reqcyc),
    .bus_req        (bus_req),
    .bus_reqtag     (bus_reqtag),
    .bus_reqack     (bus_reqack),
    .bus_respcyc    (bus_respcyc),
    .bus_resp       (bus_resp),
    .bus_resptag    (bus_resptag),
    .bus_respack    (bus_respack)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Present a request in IDLE; afterwards mem_req takes the value of keep.
  task automatic start_txn(input logic wr, input logic [63:0] addr,
                           input logic [511:0] line, input logic keep);
    mem_req      = 1'b1;
    mem_wr_en    = wr;
    mem_address  = addr;
    mem_data_out = line;
    #1;
    chk("idle_busy", mem_busy, 1'b0);
    chk("idle_reqcyc", bus_reqcyc, 1'b0);
    chk("idle_valid", mem_data_valid, 1'b0);
    nxt();
    mem_req = keep;
  endtask

  // Request word held for dly cycles, acked on the next one.
  task automatic req_phase(input logic [63:0] word, input logic [12:0] tag, input int dly);
    for (int k = 0; k <= dly; k++) begin
      bus_reqack = (k == dly);
      #1;
      chk("req_cyc", bus_reqcyc, 1'b1);
      chk("req_word", bus_req, word);
      chk("req_tag", bus_reqtag, tag);
      chk("req_novalid", mem_data_valid, 1'b0);
      nxt();
    end
    bus_reqack = 1'b0;
  endtask

  task automatic rd_beat(input logic [63:0] val, input logic gap, input logic foreign);
    if (foreign) begin
      bus_respcyc = 1'b1;
      bus_resptag = 13'h0001;
      bus_resp    = 64'hDEAD_BEEF_0BAD_F00D;
      #1;
      chk("foreign_ack", bus_respack, 1'b0);
      nxt();
    end
    if (gap) begin
      bus_respcyc = 1'b0;
      #1;
      chk("gap_ack", bus_respack, 1'b0);
      nxt();
    end
    bus_respcyc = 1'b1;
    bus_resptag = c_RD_TAG;
    bus_resp    = val;
    #1;
    chk("beat_ack", bus_respack, 1'b1);
    chk("beat_noreq", bus_reqcyc, 1'b0);
    chk("beat_novalid", mem_data_valid, 1'b0);
    nxt();
    bus_respcyc = 1'b0;
  endtask

  task automatic wr_beats(input logic [511:0] line, input int dly);
    logic [63:0] beat;
    for (int b = 0; b < 8; b++) begin
      beat = line[b*64 +: 64];
      for (int k = 0; k <= dly; k++) begin
        bus_reqack = (k == dly);
        #1;
        chk("wr_cyc", bus_reqcyc, 1'b1);
        chk("wr_beat", bus_req, beat);
        chk("wr_tag", bus_reqtag, c_WR_TAG);
        nxt();
      end
    end
    bus_reqack = 1'b0;
  endtask

  task automatic done_chk(input logic [511:0] exp);
    #1;
    chk("done_valid", mem_data_valid, 1'b1);
    chk("done_data", data_from_mem, exp);
    chk("done_busy", mem_busy, 1'b1);
    chk("done_err", mem_error, 1'b0);
    chk("done_reqcyc", bus_reqcyc, 1'b0);
    nxt();
  endtask

  logic [511:0] line_a, line_b, line_c, line_d, line_e, line_f;

  initial begin
    for (int n = 0; n < 8; n++) begin
      line_a[n*64 +: 64] = 64'h11 * (n + 1);
      line_b[n*64 +: 64] = 64'hA0 + 64'(n);
      line_c[n*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(n);
      line_d[n*64 +: 64] = 64'h100 + 64'(n);
      line_e[n*64 +: 64] = 64'h200 + 64'(n);
      line_f[n*64 +: 64] = 64'h400 + 64'(n);
    end

    // Reset state
    nxt();
    nxt();
    #1;
    chk("rst_busy", mem_busy, 1'b0);
    chk("rst_valid", mem_data_valid, 1'b0);
    chk("rst_err", mem_error, 1'b0);
    chk("rst_reqcyc", bus_reqcyc, 1'b0);
    chk("rst_req", bus_req, 64'h0);
    chk("rst_tag", bus_reqtag, 13'h0);
    chk("rst_respack", bus_respack, 1'b0);
    chk("rst_data", data_from_mem, 512'h0);
    nxt();
    rst = 1'b0;

    // Read with unaligned address, late request ack, back-to-back beats
    start_txn(1'b0, 64'h1234_5678_9ABC_DEC7, '0, 1'b0);
    req_phase(64'h1234_5678_9ABC_DEC0, c_RD_TAG, 3);
    for (int b = 0; b < 8; b++) rd_beat(line_a[b*64 +: 64], 1'b0, 1'b0);
    done_chk(line_a);

    // Write with every word acked two cycles late
    start_txn(1'b1, 64'h40, line_b, 1'b0);
    req_phase(64'h40, c_WR_TAG, 2);
    wr_beats(line_b, 2);
    done_chk(512'h0);

    // Read with foreign-tagged beats and idle gaps interleaved
    start_txn(1'b0, 64'h103F, '0, 1'b0);
    req_phase(64'h1000, c_RD_TAG, 0);
    for (int b = 0; b < 8; b++) rd_beat(line_c[b*64 +: 64], (b % 2) == 1, (b % 3) == 0);
    done_chk(line_c);

    // mem_req held through a whole read and DONE, then a second read
    start_txn(1'b0, 64'h2040, '0, 1'b1);
    req_phase(64'h2040, c_RD_TAG, 1);
    for (int b = 0; b < 8; b++) rd_beat(line_d[b*64 +: 64], 1'b0, 1'b0);
    done_chk(line_d);
    start_txn(1'b0, 64'h3000, '0, 1'b0);
    req_phase(64'h3000, c_RD_TAG, 0);
    for (int b = 0; b < 8; b++) rd_beat(line_e[b*64 +: 64], 1'b0, 1'b0);
    done_chk(line_e);

    // Reset in the middle of a read, then stray beats
    start_txn(1'b0, 64'h4000, '0, 1'b0);
    req_phase(64'h4000, c_RD_TAG, 0);
    for (int b = 0; b < 5; b++) rd_beat(64'h300 + 64'(b), 1'b0, 1'b0);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      bus_respcyc = 1'b1;
      bus_resptag = c_RD_TAG;
      bus_resp    = 64'hBAD0 + 64'(s);
      #1;
      chk("stray_ack", bus_respack, 1'b0);
      chk("stray_busy", mem_busy, 1'b0);
      chk("stray_valid", mem_data_valid, 1'b0);
      chk("stray_data", data_from_mem, 512'h0);
      chk("stray_reqcyc", bus_reqcyc, 1'b0);
      chk("stray_req", bus_req, 64'h0);
      chk("stray_tag", bus_reqtag, 13'h0);
      chk("stray_err", mem_error, 1'b0);
      nxt();
    end
    bus_respcyc = 1'b0;
    start_txn(1'b0, 64'h5000, '0, 1'b0);
    req_phase(64'h5000, c_RD_TAG, 0);
    for (int b = 0; b < 8; b++) rd_beat(line_f[b*64 +: 64], 1'b0, 1'b0);
    done_chk(line_f);
    #1;
    chk("final_busy", mem_busy, 1'b0);
    chk("final_valid", mem_data_valid, 1'b0);
    chk("final_hold", data_from_mem, line_f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Sequences one 512-bit cache-line transaction at a time between the cache arbiter's memory side and the 64-bit system bus.
- Read: issues a tagged line request, collects 8 response beats and returns the assembled line.
- Write: issues a tagged write request, then streams 8 data beats.
- Single outstanding transaction; a new request is accepted only in IDLE.

Parameters:
- ADDR_W, 64, address width of front and bus sides
- LINE_W, 512, cache line width
- BUS_W, 64, bus beat width; BEATS = LINE_W/BUS_W (8), derived, not overridable
- RD_TAG, 13'h1100, bus_reqtag value for line reads
- WR_TAG, 13'h0100, bus_reqtag value for line writes
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with MEM_BUS_CTRL_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_req  in  1  transaction request from arbiter (level)
- mem_wr_en  in  1  1 = write, 0 = read; sampled with mem_req
- mem_address  in  ADDR_W  byte address; low 6 bits ignored
- mem_data_out  in  LINE_W  write line; sampled with mem_req
- data_from_mem  out  LINE_W  assembled read line; valid with mem_data_valid
- mem_data_valid  out  1  one-cycle completion pulse (read or write)
- mem_busy  out  1  high in every state except IDLE
- mem_error  out  1  timeout pulse (0 without the macro)
- bus_reqcyc  out  1  bus request valid
- bus_req  out  BUS_W  line address (request phase) or write data beat
- bus_reqtag  out  13  RD_TAG or WR_TAG
- bus_reqack  in  1  bus accepts the current request word
- bus_respcyc  in  1  response beat valid
- bus_resp  in  BUS_W  response beat data
- bus_resptag  in  13  response tag
- bus_respack  out  1  acknowledges a response beat (same cycle)

Behaviour:
- Reset (synchronous, rst=1): state IDLE; beat counter 0; line buffer 0; all outputs 0. Reset mid-transaction aborts it with no completion pulse. Bus responses arriving after reset are ignored (not acked).
- States: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_DATA, DONE.
- IDLE:
  - On mem_req=1, latch aligned address {mem_address[63:6],6'b0}, mem_wr_en and mem_data_out.
  - Go to WR_REQ if mem_wr_en=1, else RD_REQ.
  - mem_req while not in IDLE is ignored.
- RD_REQ / WR_REQ:
  - Drive bus_reqcyc=1, bus_req=latched address, bus_reqtag=RD_TAG or WR_TAG.
  - Hold until bus_reqack=1, then go to RD_RESP or WR_DATA with counter=0.
- RD_RESP:
  - Each cycle with bus_respcyc=1 and bus_resptag==RD_TAG: store bus_resp into beat[counter], assert bus_respack combinationally the same cycle, increment counter.
  - A beat with a mismatched tag is not stored and not acked.
  - Gaps between beats are allowed.
  - After beat 7 is stored, go to DONE.
- WR_DATA:
  - Drive bus_reqcyc=1, bus_req=beat[counter] of the latched line, bus_reqtag=WR_TAG.
  - Each beat is held until bus_reqack; counter increments on ack.
  - Ack of beat 7 goes to DONE.
- Beat order: beat n = line bits [64n+63:64n], n = 0..7 ascending, for reads and writes.
- DONE (one cycle):
  - mem_data_valid=1.
  - Read: data_from_mem = assembled line.
  - Write: data_from_mem = 0.
  - Next state IDLE. mem_busy=1 in DONE.
- Latency: earliest next acceptance is the cycle after DONE.
  - Read minimum: 1 request + 8 beats + 1 DONE = 10 cycles.
  - Write minimum: 1 + 8 + 1 = 10 cycles.
- data_from_mem holds its value between pulses; it is only meaningful while mem_data_valid=1.
- bus_respcyc in any state other than RD_RESP: ignored, bus_respack=0.
- Counter is 3 bits; it is never allowed to wrap within a transaction.

Optional Feature:
- MEM_BUS_CTRL_TIMEOUT_EN defined:
  - A watchdog counts consecutive cycles without progress in RD_REQ, RD_RESP, WR_REQ and WR_DATA. Progress = bus_reqack, or an accepted response beat.
  - When the count reaches TIMEOUT_CYCLES, go to IDLE and pulse mem_error=1 together with mem_data_valid=1 and data_from_mem=0.
  - The watchdog clears on progress and on reset.
- Not defined: the block waits indefinitely; mem_error is tied to 0.

Test Plan:
- Read 0x1234_5678_9ABC_DEC7, ack after 3 cycles, 8 beats 0x11..0x88 with tag 13'h1100 and no gaps:
  - bus_req = 0x1234_5678_9ABC_DEC0.
  - mem_data_valid pulses once.
  - data_from_mem[63:0]=0x11 ... [511:448]=0x88.
- Write line (beat n = 0xA0+n) to 0x40, bus_reqack delayed 2 cycles per beat:
  - Request word is 0x40 with tag 13'h0100.
  - Data beats 0xA0..0xA7 in order, each held until ack.
  - Single completion pulse.
- Read with interleaved beats tagged 13'h0001 and idle gaps:
  - Foreign beats are not acked or stored.
  - Line assembled from 8 correct beats only.
- mem_req held high during a read plus a second request in DONE:
  - Exactly one bus request per transaction.
  - Next request starts the cycle after DONE.
- rst=1 after beat 4 of a read, then 3 stray response beats:
  - All outputs 0, no mem_data_valid.
  - Stray beats are not acked.
  - A subsequent read completes correctly.
- With MEM_BUS_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, bus never acks:
  - mem_error and mem_data_valid pulse together after 16 cycles.
  - State returns to IDLE.
